// File: rtl/demux_pkg.sv
// demux_pkg
// Shared definitions for the 1-to-2 packet stream demultiplexer:
//   - default payload width and per-port buffer depth
//   - routing FSM state encoding
//   - width of the per-port delivered-packet counters
package demux_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int DEPTH_DEF  = 2;
  localparam int PKT_CNT_W  = 16;

  // state  | meaning
  // IDLE   | between packets; next accepted beat is a first beat
  // ROUTE0 | mid-packet, beats go to port 0 until s_last
  // ROUTE1 | mid-packet, beats go to port 1 until s_last
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROUTE0 = 2'd1,
    ROUTE1 = 2'd2
  } state_t;

endpackage

// File: rtl/demux_fifo.sv
// demux_fifo
// Per-port output buffer holding {last, data} entries. Occupancy is tracked
// with an explicit count so full/empty need no extra pointer bit, and both
// pointers wrap at DEPTH (DEPTH need not be a power of two).
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   push             write push_data/push_last (ignored when full)
//   push_data/last   entry to write
//   pop              drop head entry (ignored when empty)
//   head_data/last   head entry, forced to 0 while empty
//   full, empty      occupancy flags
module demux_fifo
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  input  logic              pop,
  output logic [DATA_W-1:0] head_data,
  output logic              head_last,
  output logic              full,
  output logic              empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W:0]    mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic [CNT_W-1:0]   count;
  logic               do_push;
  logic               do_pop;
  logic [DATA_W:0]    head_entry;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  // Storage carries no reset; stale entries are hidden by the empty gating
  // on the head outputs below.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= {push_last, push_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= next_ptr(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= next_ptr(rd_ptr);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  assign head_entry = mem[rd_ptr];
  assign head_data  = empty ? '0   : head_entry[DATA_W-1:0];
  assign head_last  = empty ? 1'b0 : head_entry[DATA_W];

endmodule

// File: rtl/demux1to2_stream.sv
// demux1to2_stream
// Routes whole packets from one valid/ready input stream to one of two
// output streams. The destination is s_sel on the first accepted beat and
// is held until the beat carrying s_last is accepted. Each output has its
// own buffer so a stalled port never blocks the other from draining.
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   s_valid/ready/data/last  input stream
//   s_sel                    destination of a packet (first beat only)
//   m0_* / m1_*              output streams, valid = buffer non-empty
//   pkt_cnt0 / pkt_cnt1      wrapping count of packets delivered per port
module demux1to2_stream
  import demux_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [DATA_W-1:0]    s_data,
  input  logic                 s_last,
  input  logic                 s_sel,
  output logic                 m0_valid,
  input  logic                 m0_ready,
  output logic [DATA_W-1:0]    m0_data,
  output logic                 m0_last,
  output logic                 m1_valid,
  input  logic                 m1_ready,
  output logic [DATA_W-1:0]    m1_data,
  output logic                 m1_last,
  output logic [PKT_CNT_W-1:0] pkt_cnt0,
  output logic [PKT_CNT_W-1:0] pkt_cnt1
);

  state_t state;
  logic   run;
  logic   target;
  logic   accept;
  logic   push0;
  logic   push1;
  logic   pop0;
  logic   pop1;
  logic   full0;
  logic   full1;
  logic   empty0;
  logic   empty1;

  // Mid-packet the target is locked by the state; between packets the
  // current s_sel decides which buffer's space gates s_ready.
  always_comb begin
    target = 1'b0;
    case (state)
      ROUTE0:  target = 1'b0;
      ROUTE1:  target = 1'b1;
      default: target = s_sel;
    endcase
  end

  // run holds s_ready low through reset and until the first edge after
  // release. Readiness looks only at buffer space, never at mX_ready.
  assign s_ready = run & (target ? ~full1 : ~full0);
  assign accept  = s_valid & s_ready;
  assign push0   = accept & ~target;
  assign push1   = accept & target;

  assign m0_valid = ~empty0;
  assign m1_valid = ~empty1;
  assign pop0     = m0_valid & m0_ready;
  assign pop1     = m1_valid & m1_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      run      <= 1'b0;
      pkt_cnt0 <= '0;
      pkt_cnt1 <= '0;
    end else begin
      run <= 1'b1;
      if (accept) begin
        case (state)
          IDLE: begin
            // single-beat packets never leave IDLE
            if (!s_last) begin
              state <= s_sel ? ROUTE1 : ROUTE0;
            end
          end
          ROUTE0, ROUTE1: begin
            if (s_last) begin
              state <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
      if (pop0 && m0_last) begin
        pkt_cnt0 <= pkt_cnt0 + 1'b1;
      end
      if (pop1 && m1_last) begin
        pkt_cnt1 <= pkt_cnt1 + 1'b1;
      end
    end
  end

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push0),
    .push_data (s_data),
    .push_last (s_last),
    .pop       (pop0),
    .head_data (m0_data),
    .head_last (m0_last),
    .full      (full0),
    .empty     (empty0)
  );

  demux_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push1),
    .push_data (s_data),
    .push_last (s_last),
    .pop       (pop1),
    .head_data (m1_data),
    .head_last (m1_last),
    .full      (full1),
    .empty     (empty1)
  );

endmodule

// File: tb/tb_demux1to2_stream.sv
// tb_demux1to2_stream
// Directed bench for demux1to2_stream with DATA_W=32, DEPTH=2. Output
// handshakes are recorded into per-port queues and compared against
// hand-written expected beats.
module tb_demux1to2_stream;
  import demux_pkg::*;

  localparam int BOUND = 200;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] s_data;
  logic        s_last;
  logic        s_sel;
  logic        m0_valid;
  logic        m0_ready;
  logic [31:0] m0_data;
  logic        m0_last;
  logic        m1_valid;
  logic        m1_ready;
  logic [31:0] m1_data;
  logic        m1_last;
  logic [15:0] pkt_cnt0;
  logic [15:0] pkt_cnt1;

  int vectors = 0;
  int miscompares = 0;

  logic [32:0] q0[$];
  logic [32:0] q1[$];
  logic        m0_seen = 1'b0;

  demux1to2_stream dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .s_data   (s_data),
    .s_last   (s_last),
    .s_sel    (s_sel),
    .m0_valid (m0_valid),
    .m0_ready (m0_ready),
    .m0_data  (m0_data),
    .m0_last  (m0_last),
    .m1_valid (m1_valid),
    .m1_ready (m1_ready),
    .m1_data  (m1_data),
    .m1_last  (m1_last),
    .pkt_cnt0 (pkt_cnt0),
    .pkt_cnt1 (pkt_cnt1)
  );

  always #5 clk = ~clk;

  // Inputs only change 1 unit after a rising edge, so a handshake seen at
  // the falling edge is the one that completes at the next rising edge.
  always @(negedge clk) begin
    if (m0_valid) m0_seen = 1'b1;
    if (m0_valid && m0_ready) q0.push_back({m0_last, m0_data});
    if (m1_valid && m1_ready) q1.push_back({m1_last, m1_data});
  end

  initial begin
    #20_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [31:0] d, input logic l, input logic sel);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = l;
    s_sel   = sel;
    @(negedge clk);
    while (!s_ready && n < BOUND) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 64'(n < BOUND), 64'd1);
    @(posedge clk);
    #1;
    s_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    s_valid  = 1'b0;
    s_data   = '0;
    s_last   = 1'b0;
    s_sel    = 1'b0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;

    // reset state
    idle_cycles(2);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_m0_valid", 64'(m0_valid), 64'd0);
    chk("rst_m1_valid", 64'(m1_valid), 64'd0);
    chk("rst_m0_data", 64'(m0_data), 64'd0);
    chk("rst_m1_last", 64'(m1_last), 64'd0);
    chk("rst_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("rst_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_s_ready_before_edge", 64'(s_ready), 64'd0);
    @(posedge clk);
    #1;
    chk("rel_s_ready_after_edge", 64'(s_ready), 64'd1);

    // basic routing to port 1
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    m0_seen  = 1'b0;
    send(32'hA0, 1'b0, 1'b1);
    send(32'hA1, 1'b0, 1'b1);
    send(32'hA2, 1'b1, 1'b1);
    idle_cycles(4);
    chk("route_q1_size", 64'(q1.size()), 64'd3);
    if (q1.size() == 3) begin
      chk("route_beat0", 64'(q1[0]), {31'd0, 1'b0, 32'hA0});
      chk("route_beat1", 64'(q1[1]), {31'd0, 1'b0, 32'hA1});
      chk("route_beat2", 64'(q1[2]), {31'd0, 1'b1, 32'hA2});
    end
    chk("route_m0_never_valid", 64'(m0_seen), 64'd0);
    chk("route_pkt_cnt1", 64'(pkt_cnt1), 64'd1);
    q0.delete();
    q1.delete();

    // select toggles mid-packet, all beats stay on port 0
    send(32'hB0, 1'b0, 1'b0);
    send(32'hB1, 1'b0, 1'b1);
    send(32'hB2, 1'b0, 1'b0);
    send(32'hB3, 1'b1, 1'b1);
    idle_cycles(4);
    chk("sel_q0_size", 64'(q0.size()), 64'd4);
    chk("sel_q1_size", 64'(q1.size()), 64'd0);
    if (q0.size() == 4) begin
      chk("sel_beat0", 64'(q0[0]), {31'd0, 1'b0, 32'hB0});
      chk("sel_beat1", 64'(q0[1]), {31'd0, 1'b0, 32'hB1});
      chk("sel_beat2", 64'(q0[2]), {31'd0, 1'b0, 32'hB2});
      chk("sel_beat3", 64'(q0[3]), {31'd0, 1'b1, 32'hB3});
    end
    chk("sel_pkt_cnt0", 64'(pkt_cnt0), 64'd1);
    q0.delete();

    // backpressure on port 0 with a 5-beat packet
    m0_ready = 1'b0;
    send(32'hC0, 1'b0, 1'b0);
    chk("lat_m0_valid", 64'(m0_valid), 64'd1);
    chk("lat_m0_data", 64'(m0_data), 64'hC0);
    chk("lat_m0_last", 64'(m0_last), 64'd0);
    send(32'hC1, 1'b0, 1'b0);
    s_valid = 1'b1;
    s_data  = 32'hC2;
    s_last  = 1'b0;
    s_sel   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_s_ready_low", 64'(s_ready), 64'd0);
    end
    @(posedge clk);
    #1;
    m0_ready = 1'b1;
    send(32'hC2, 1'b0, 1'b1);
    send(32'hC3, 1'b0, 1'b0);
    send(32'hC4, 1'b1, 1'b1);
    idle_cycles(5);
    chk("bp_q0_size", 64'(q0.size()), 64'd5);
    if (q0.size() == 5) begin
      chk("bp_beat0", 64'(q0[0]), {31'd0, 1'b0, 32'hC0});
      chk("bp_beat1", 64'(q0[1]), {31'd0, 1'b0, 32'hC1});
      chk("bp_beat2", 64'(q0[2]), {31'd0, 1'b0, 32'hC2});
      chk("bp_beat3", 64'(q0[3]), {31'd0, 1'b0, 32'hC3});
      chk("bp_beat4", 64'(q0[4]), {31'd0, 1'b1, 32'hC4});
    end
    chk("bp_q1_size", 64'(q1.size()), 64'd0);
    chk("bp_pkt_cnt0", 64'(pkt_cnt0), 64'd2);
    q0.delete();

    // port 0 stalled and full, port 1 still drains
    m1_ready = 1'b0;
    send(32'hD0, 1'b0, 1'b1);
    send(32'hD1, 1'b1, 1'b1);
    m0_ready = 1'b0;
    send(32'hE0, 1'b1, 1'b0);
    send(32'hE1, 1'b1, 1'b0);
    s_valid  = 1'b1;
    s_data   = 32'hF0;
    s_last   = 1'b1;
    s_sel    = 1'b0;
    m1_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ind_s_ready_low", 64'(s_ready), 64'd0);
    end
    chk("ind_q1_size", 64'(q1.size()), 64'd2);
    if (q1.size() == 2) begin
      chk("ind_m1_beat0", 64'(q1[0]), {31'd0, 1'b0, 32'hD0});
      chk("ind_m1_beat1", 64'(q1[1]), {31'd0, 1'b1, 32'hD1});
    end
    chk("ind_pkt_cnt1", 64'(pkt_cnt1), 64'd2);
    chk("ind_q0_size_stalled", 64'(q0.size()), 64'd0);
    @(posedge clk);
    #1;
    m0_ready = 1'b1;
    send(32'hF0, 1'b1, 1'b0);
    idle_cycles(5);
    chk("ind_q0_size", 64'(q0.size()), 64'd3);
    if (q0.size() == 3) begin
      chk("ind_m0_beat0", 64'(q0[0]), {31'd0, 1'b1, 32'hE0});
      chk("ind_m0_beat1", 64'(q0[1]), {31'd0, 1'b1, 32'hE1});
      chk("ind_m0_beat2", 64'(q0[2]), {31'd0, 1'b1, 32'hF0});
    end
    chk("ind_pkt_cnt0", 64'(pkt_cnt0), 64'd5);
    q0.delete();
    q1.delete();

    // reset in the middle of a packet
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    send(32'h10, 1'b0, 1'b0);
    send(32'h11, 1'b0, 1'b1);
    rst_n = 1'b0;
    #2;
    chk("mid_rst_state", 64'(dut.state), 64'(IDLE));
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_m0_valid", 64'(m0_valid), 64'd0);
    chk("mid_rst_m0_data", 64'(m0_data), 64'd0);
    chk("mid_rst_m0_last", 64'(m0_last), 64'd0);
    chk("mid_rst_m1_valid", 64'(m1_valid), 64'd0);
    chk("mid_rst_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    chk("mid_rst_pkt_cnt1", 64'(pkt_cnt1), 64'd0);
    idle_cycles(2);
    rst_n    = 1'b1;
    m0_ready = 1'b1;
    m1_ready = 1'b1;
    q0.delete();
    q1.delete();
    send(32'h20, 1'b1, 1'b1);
    idle_cycles(3);
    chk("post_rst_q1_size", 64'(q1.size()), 64'd1);
    if (q1.size() == 1) begin
      chk("post_rst_beat", 64'(q1[0]), {31'd0, 1'b1, 32'h20});
    end
    chk("post_rst_q0_size", 64'(q0.size()), 64'd0);
    chk("post_rst_pkt_cnt1", 64'(pkt_cnt1), 64'd1);
    chk("post_rst_pkt_cnt0", 64'(pkt_cnt0), 64'd0);
    q1.delete();

    // counter wrap on port 0
    for (int i = 0; i < 65535; i++) begin
      send(32'(i), 1'b1, 1'b0);
    end
    idle_cycles(3);
    chk("wrap_pkt_cnt0_max", 64'(pkt_cnt0), 64'hFFFF);
    send(32'hFEED, 1'b1, 1'b0);
    idle_cycles(3);
    chk("wrap_pkt_cnt0_zero", 64'(pkt_cnt0), 64'h0000);
    chk("wrap_q0_size", 64'(q0.size()), 64'd65536);
    if (q0.size() == 65536) begin
      chk("wrap_first", 64'(q0[0]), {31'd0, 1'b1, 32'h0});
      chk("wrap_last", 64'(q0[65535]), {31'd0, 1'b1, 32'hFEED});
    end
    chk("wrap_pkt_cnt1", 64'(pkt_cnt1), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/demux1to2_stream.md
DEMUX1TO2_STREAM -- requirements
Module: demux1to2_stream

Interface
REQ-001 The block SHALL take parameter DATA_W, default 32, as the payload width in bits.
REQ-002 The block SHALL take parameter DEPTH, default 2, as the entries per output buffer; legal values are 2..16.
REQ-003 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-004 The block SHALL have these ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid and s_ready are both 1
s_data  in  DATA_W  input payload
s_last  in  1  final beat of the packet
s_sel  in  1  destination, 0 = port 0, 1 = port 1; sampled on the first beat only
m0_valid, m1_valid  out  1  output beat valid
m0_ready, m1_ready  in  1  downstream accept
m0_data, m1_data  out  DATA_W  output payload
m0_last, m1_last  out  1  final-beat marker
pkt_cnt0, pkt_cnt1  out  16  packets fully delivered per port, wrapping

Function
REQ-005 The block SHALL route whole packets; the destination SHALL be s_sel sampled on the first accepted beat of a packet.
REQ-006 The destination SHALL be held until the beat with s_last=1 is accepted; s_sel on later beats SHALL be ignored.
REQ-007 The FSM SHALL have the states IDLE, ROUTE0 and ROUTE1.
- IDLE: next packet not yet started.
- IDLE to ROUTE0 or ROUTE1: first beat accepted with s_last=0.
- ROUTEx to IDLE: accepted beat with s_last=1.
- Single-beat packet (first beat has s_last=1): stays in IDLE.
REQ-008 The s_ready signal SHALL be 1 only when the current target buffer holds fewer than DEPTH entries.
- Target in IDLE: s_sel.
- Target in ROUTEx: buffer x.
- s_ready SHALL NOT depend on m0_ready or m1_ready (no full-buffer pass-through).
REQ-009 Each output buffer SHALL be a FIFO of {data, last}; mX_valid SHALL be 1 whenever buffer X is non-empty, and mX_data/mX_last SHALL show the head entry.
REQ-010 Latency SHALL be one cycle: a beat accepted at edge N is visible on mX at edge N, with mX_valid=1 in the cycle after the accepting edge.
REQ-011 A push and a pop on the same buffer in the same cycle SHALL leave its occupancy unchanged.
- A non-full buffer SHALL accept both.
- A full buffer SHALL accept only the pop (per REQ-008).
REQ-012 The two output ports SHALL drain independently; a stall on one SHALL NOT block draining of the other.
REQ-013 pkt_cntX SHALL increment by 1 when mX_valid, mX_ready and mX_last are all 1, and SHALL wrap from 0xFFFF to 0x0000.
REQ-014 Beat order within each port SHALL be preserved; beats SHALL never be duplicated or dropped.
REQ-015 While s_valid=1 and s_ready=0, the upstream holds s_data, s_last and s_sel stable; the block SHALL NOT sample them until acceptance.

Reset
REQ-016 While rst_n=0, the following SHALL apply:
- state = IDLE;
- both buffers empty;
- m0_valid = m1_valid = 0;
- s_ready = 0;
- pkt_cnt0 = pkt_cnt1 = 0;
- mX_data and mX_last SHALL be 0.
REQ-017 Reset asserted mid-packet SHALL discard all buffered beats and the partial packet; after release, the next accepted beat is a first beat.
REQ-018 s_ready SHALL rise no earlier than the first clk edge after rst_n deasserts.

Structure
REQ-019 A shared package demux_pkg SHALL hold the DATA_W default, the DEPTH default, the state enum (IDLE, ROUTE0, ROUTE1) and the counter width of 16.
REQ-020 The output buffer SHALL be a sub-module demux_fifo, instantiated once per port, with count-based full/empty and pointer wrap at DEPTH.

Verification
REQ-021 Basic routing: 3-beat packet, s_sel=1 with data 0xA0,0xA1,0xA2, m1_ready=1 -> the beats appear on m1 in order with m1_last on 0xA2, m0_valid stays 0, and pkt_cnt1 reads 1.
REQ-022 Mid-packet select change: s_sel toggles on beats 2-4 of a 4-beat packet started with s_sel=0 -> all 4 beats appear on m0 only.
REQ-023 Backpressure: m0_ready=0 and a 5-beat packet to port 0 with DEPTH=2 -> s_ready drops after 2 beats; releasing m0_ready delivers all 5 beats with no loss.
REQ-024 Independent drain: m0 stalled and full, then a 1-beat packet waiting for port 0 -> s_ready=0 while m1 continues to drain its earlier buffered beats.
REQ-025 Counter wrap: preload 65535 single-beat packets to port 0, then send one more -> pkt_cnt0 reads 0x0000.
REQ-026 Reset mid-packet: rst_n pulsed low after beat 2 of a 4-beat packet -> all outputs read zero and state is IDLE; the next beat, sent with s_sel=1, routes to port 1.
